// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Wide add/subtract (W = 4*NIBBLES bits) built by time-sharing one 4-bit
//   ripple-carry slice, one nibble per clock, least significant nibble first.
//   Operands are captured on an accepted START. The carry is carried from one
//   nibble to the next through a register. The result is flagged by a
//   one-cycle DONE pulse.
//
// Ports
//   CLK    in   1  rising-edge clock
//   RST_N  in   1  asynchronous active-low reset
//   START  in   1  request strobe, accepted only in IDLE or DONE
//   SUB    in   1  0: A+B+CIN, 1: A-B (CIN ignored)
//   CIN    in   1  carry-in for add
//   A      in   W  operand A
//   B      in   W  operand B
//   BUSY   out  1  nibbles being processed
//   DONE   out  1  one-cycle result-valid pulse
//   SUM    out  W  result (valid from DONE until the next accepted START)
//   COUT   out  1  carry out of the MSB (subtract: 1 = no borrow)
//   OVF    out  1  two's-complement overflow

// 4-bit ripple-carry adder slice.
module nsa_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < 4; gi++) begin : g_fa
    assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign co = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic                 SUB,
  input  logic                 CIN,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*NIBBLES-1:0] SUM,
  output logic                 COUT,
  output logic                 OVF
);
  localparam int W  = 4 * NIBBLES;
  // Keep the counter at least one bit wide so NIBBLES=1 still elaborates.
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;      // already inverted for subtract
  logic [W-1:0]  sum_reg, sum_next;
  logic [CW-1:0] cnt_reg;
  logic          carry_reg;
  logic          cout_reg;
  logic          ovf_reg;

  logic          accept;
  logic          last_nib;
  logic [3:0]    a_nib [NIBBLES];
  logic [3:0]    b_nib [NIBBLES];
  logic [3:0]    a_cur, b_cur;
  logic [3:0]    slice_sum;
  logic          slice_cout;

  // START is honoured only when no operation is in flight.
  assign accept   = START && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign last_nib = (cnt_reg == LAST_NIB);

  // Split the latched operands into nibbles. The counter then selects the
  // nibble that feeds the slice.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi] = a_reg[4*gi +: 4];
    assign b_nib[gi] = b_reg[4*gi +: 4];
  end

  assign a_cur = a_nib[cnt_reg];
  assign b_cur = b_nib[cnt_reg];

  nsa_slice u_slice (
    .a  (a_cur),
    .b  (b_cur),
    .ci (carry_reg),
    .s  (slice_sum),
    .co (slice_cout)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  state_next = START ? S_RUN : S_IDLE;
      S_RUN:   state_next = last_nib ? S_DONE : S_RUN;
      S_DONE:  state_next = START ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    case (state_reg)
      S_RUN:   BUSY = 1'b1;
      S_DONE:  DONE = 1'b1;
      default: ;
    endcase
  end

  // Merge the current slice result into the nibble that the counter selects.
  always_comb begin
    sum_next = sum_reg;
    if (state_reg == S_RUN) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (cnt_reg == CW'(i)) begin
          sum_next[4*i +: 4] = slice_sum;
        end
      end
    end
  end

  // ---------------- Datapath ----------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      // Subtract is A + ~B + 1: invert B once here and seed the carry with 1.
      a_reg     <= A;
      b_reg     <= SUB ? ~B : B;
      carry_reg <= SUB ? 1'b1 : CIN;
      cnt_reg   <= '0;
    end else if (state_reg == S_RUN) begin
      sum_reg   <= sum_next;
      carry_reg <= slice_cout;
      if (last_nib) begin
        cnt_reg  <= '0;
        // The flags come straight from the final slice, so they are valid
        // in the same cycle as DONE.
        cout_reg <= slice_cout;
        ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (slice_sum[3] != a_reg[W-1]);
      end else begin
        cnt_reg  <= cnt_reg + 1'b1;
      end
    end
  end

  assign SUM  = sum_reg;
  assign COUT = cout_reg;
  assign OVF  = ovf_reg;

endmodule
